i2c_sht40_target: RTL and testbench

I2C_SHT40_TARGET -- requirements
Module: i2c_sht40_target

---
 rtl/i2c_sht40_target.sv | 215 +++++++++++++++++++++
 tb/tb_i2c_sht40_target.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_sht40_target.sv
// I2C target that snapshots a temperature/humidity pair on a command and serves it as a 6-byte read.
// Optional macro I2C_TARGET_CRC_EN: emit CRC-8 (poly 0x31, init 0xFF) check bytes instead of constant 0xFF.
module i2c_sht40_target #(
  parameter logic [6:0] TARGET_ADDRESS = 7'h44,
  parameter logic [7:0] MEAS_COMMAND   = 8'hFD
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Scl_Data,
  inout  wire         Sda_Data,
  input  logic [15:0] Temperature_Data,
  input  logic [15:0] Humidity_Data,
  output logic [7:0]  Command_Received,
  output logic        Command_Valid,
  output logic        Measurement_Valid,
  output logic [2:0]  Bytes_Sent,
  output logic [2:0]  Target_State_Out
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    CMD_RX   = 3'd3,
    CMD_ACK  = 3'd4,
    TX_BYTE  = 3'd5,
    TX_ACK   = 3'd6,
    WAIT     = 3'd7
  } state_t;

  state_t      state;
  logic        scl_s1, scl_s2, scl_q;
  logic        sda_s1, sda_s2, sda_q;
  logic [3:0]  bit_cnt;
  logic [7:0]  rx_sh;
  logic [7:0]  tx_sh;
  logic        sda_oe;
  logic [15:0] t_snap, h_snap;
  logic [7:0]  crc_t, crc_h;
  logic [7:0]  tx_next;
  logic [7:0]  rx_byte;
  logic        scl_rise, scl_fall, start_det, stop_det;

  assign Sda_Data         = sda_oe ? 1'b0 : 1'bz;
  assign Target_State_Out = state;

  assign scl_rise  = scl_s2 & ~scl_q;
  assign scl_fall  = ~scl_s2 & scl_q;
  assign start_det = scl_s2 & scl_q & sda_q & ~sda_s2;
  assign stop_det  = scl_s2 & scl_q & ~sda_q & sda_s2;
  assign rx_byte   = {rx_sh[6:0], sda_s2};

`ifdef I2C_TARGET_CRC_EN
  function automatic logic [7:0] crc8(input logic [15:0] word);
    logic [7:0]  crc;
    logic [15:0] w;
    crc = 8'hFF;
    w   = word;
    for (int unsigned i = 0; i < 16; i++) begin
      crc = (crc[7] ^ w[15]) ? ({crc[6:0], 1'b0} ^ 8'h31) : {crc[6:0], 1'b0};
      w   = {w[14:0], 1'b0};
    end
    return crc;
  endfunction

  assign crc_t = crc8(t_snap);
  assign crc_h = crc8(h_snap);
`else
  assign crc_t = 8'hFF;
  assign crc_h = 8'hFF;
`endif

  // Byte to load next is indexed by how many bytes have already been acknowledged.
  always_comb begin
    tx_next = 8'hFF;
    case (Bytes_Sent)
      3'd0:    tx_next = t_snap[15:8];
      3'd1:    tx_next = t_snap[7:0];
      3'd2:    tx_next = crc_t;
      3'd3:    tx_next = h_snap[15:8];
      3'd4:    tx_next = h_snap[7:0];
      3'd5:    tx_next = crc_h;
      default: tx_next = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      scl_s1            <= 1'b1;
      scl_s2            <= 1'b1;
      scl_q             <= 1'b1;
      sda_s1            <= 1'b1;
      sda_s2            <= 1'b1;
      sda_q             <= 1'b1;
      state             <= IDLE;
      bit_cnt           <= '0;
      rx_sh             <= '0;
      tx_sh             <= '0;
      sda_oe            <= 1'b0;
      t_snap            <= '0;
      h_snap            <= '0;
      Command_Received  <= '0;
      Command_Valid     <= 1'b0;
      Measurement_Valid <= 1'b0;
      Bytes_Sent        <= '0;
    end else begin
      scl_s1        <= Scl_Data;
      scl_s2        <= scl_s1;
      scl_q         <= scl_s2;
      sda_s1        <= Sda_Data;
      sda_s2        <= sda_s1;
      sda_q         <= sda_s2;
      Command_Valid <= 1'b0;

      if (start_det) begin
        state      <= ADDR;
        bit_cnt    <= '0;
        sda_oe     <= 1'b0;
        Bytes_Sent <= '0;
      end else if (stop_det) begin
        state   <= IDLE;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            rx_sh   <= rx_byte;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= '0;
              if (rx_byte[7:1] == TARGET_ADDRESS && (!rx_byte[0] || Measurement_Valid))
                state <= ADDR_ACK;
              else
                state <= WAIT;
            end
          end

          // First falling edge starts the ACK drive, the second ends it.
          ADDR_ACK: if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe <= 1'b1;
            end else if (rx_sh[0]) begin
              state  <= TX_BYTE;
              tx_sh  <= tx_next;
              sda_oe <= ~tx_next[7];
            end else begin
              state  <= CMD_RX;
              sda_oe <= 1'b0;
            end
          end

          CMD_RX: if (scl_rise) begin
            rx_sh   <= rx_byte;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt          <= '0;
              Command_Received <= rx_byte;
              Command_Valid    <= 1'b1;
              if (rx_byte == MEAS_COMMAND) begin
                t_snap            <= Temperature_Data;
                h_snap            <= Humidity_Data;
                Measurement_Valid <= 1'b1;
              end
              state <= CMD_ACK;
            end
          end

          CMD_ACK: if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe <= 1'b1;
            end else begin
              sda_oe <= 1'b0;
              state  <= WAIT;
            end
          end

          TX_BYTE: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                state   <= TX_ACK;
              end else begin
                sda_oe <= ~tx_sh[6];
                tx_sh  <= {tx_sh[6:0], 1'b0};
              end
            end
          end

          // A falling edge here implies the master ACKed, otherwise we already left.
          TX_ACK: begin
            if (scl_rise) begin
              Bytes_Sent <= Bytes_Sent + 3'd1;
              if (Bytes_Sent == 3'd5) begin
                Measurement_Valid <= 1'b0;
                state             <= WAIT;
              end else if (sda_s2) begin
                state <= WAIT;
              end
            end else if (scl_fall) begin
              tx_sh  <= tx_next;
              sda_oe <= ~tx_next[7];
              state  <= TX_BYTE;
            end
          end

          default: sda_oe <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_sht40_target.sv
// Directed bench for i2c_sht40_target: bit-banged I2C master with hand-computed expectations.
module tb_i2c_sht40_target;

  localparam int Q = 40;

`ifdef I2C_TARGET_CRC_EN
  localparam logic [7:0] CRC_T = 8'h92;
  localparam logic [7:0] CRC_H = 8'h37;
`else
  localparam logic [7:0] CRC_T = 8'hFF;
  localparam logic [7:0] CRC_H = 8'hFF;
`endif

  logic        clk = 1'b0;
  logic        Reset;
  logic        m_scl;
  logic        m_sda;
  logic [15:0] temp, hum;
  wire         sda_bus;
  logic [7:0]  cmd;
  logic        cv, mv;
  logic [2:0]  bs, st;

  int checks    = 0;
  int failures  = 0;
  int cv_count  = 0;
  int unstable  = 0;

  pullup (sda_bus);
  assign sda_bus = m_sda ? 1'bz : 1'b0;

  always #5 clk = ~clk;
  always @(negedge clk) if (cv) cv_count++;

  i2c_sht40_target #(.TARGET_ADDRESS(7'h44), .MEAS_COMMAND(8'hFD)) dut (
    .clk               (clk),
    .Reset             (Reset),
    .Scl_Data          (m_scl),
    .Sda_Data          (sda_bus),
    .Temperature_Data  (temp),
    .Humidity_Data     (hum),
    .Command_Received  (cmd),
    .Command_Valid     (cv),
    .Measurement_Valid (mv),
    .Bytes_Sent        (bs),
    .Target_State_Out  (st)
  );

  task automatic clk_bit(input logic b, output logic r);
    m_sda = b;
    #Q m_scl = 1'b1;
    #Q r = sda_bus;
    #Q if (sda_bus !== r) unstable++;
    m_scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    #Q m_scl = 1'b1;
    #Q m_sda = 1'b0;
    #Q m_scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    #Q m_scl = 1'b1;
    #Q m_sda = 1'b1;
    #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic [7:0] s;
    logic r;
    s = b;
    for (int i = 0; i < 8; i++) begin
      clk_bit(s[7], r);
      s = {s[6:0], 1'b0};
    end
    clk_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic r;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      clk_bit(1'b1, r);
      d = {d[6:0], r};
    end
    clk_bit(~ack, r);
  endtask

  task automatic pulse_reset();
    @(negedge clk) Reset = 1'b1;
    repeat (2) @(negedge clk);
    Reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_meas(input logic [15:0] t, input logic [15:0] h);
    logic a0, a1;
    temp = t;
    hum  = h;
    i2c_start();
    write_byte(8'h88, a0);
    write_byte(8'hFD, a1);
    i2c_stop();
    checks++; if (a0 !== 1'b1 || a1 !== 1'b1) begin failures++; $display("FAIL meas_setup_ack got=%b%b exp=11", a0, a1); end
  endtask

  task automatic test_reset();
    Reset = 1'b1; m_scl = 1'b1; m_sda = 1'b1; temp = '0; hum = '0;
    repeat (3) @(negedge clk);
    checks++; if (st !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", st); end
    checks++; if (cmd !== 8'h00) begin failures++; $display("FAIL reset_cmd got=%h exp=00", cmd); end
    checks++; if (cv !== 1'b0) begin failures++; $display("FAIL reset_cv got=%b exp=0", cv); end
    checks++; if (mv !== 1'b0) begin failures++; $display("FAIL reset_mv got=%b exp=0", mv); end
    checks++; if (bs !== 3'd0) begin failures++; $display("FAIL reset_bytes got=%0d exp=0", bs); end
    checks++; if (sda_bus !== 1'b1) begin failures++; $display("FAIL reset_sda got=%b exp=1", sda_bus); end
    Reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (st !== 3'd0) begin failures++; $display("FAIL reset_release_state got=%0d exp=0", st); end
  endtask

  task automatic test_write_meas();
    logic a0, a1;
    int n0;
    n0 = cv_count;
    temp = 16'hBEEF; hum = 16'h1234;
    i2c_start();
    write_byte(8'h88, a0);
    write_byte(8'hFD, a1);
    i2c_stop();
    checks++; if (a0 !== 1'b1) begin failures++; $display("FAIL wr_addr_ack got=%b exp=1", a0); end
    checks++; if (a1 !== 1'b1) begin failures++; $display("FAIL wr_cmd_ack got=%b exp=1", a1); end
    checks++; if (cmd !== 8'hFD) begin failures++; $display("FAIL wr_cmd got=%h exp=FD", cmd); end
    checks++; if (cv_count - n0 !== 1) begin failures++; $display("FAIL wr_cv_pulses got=%0d exp=1", cv_count - n0); end
    checks++; if (mv !== 1'b1) begin failures++; $display("FAIL wr_mv got=%b exp=1", mv); end
    checks++; if (st !== 3'd0) begin failures++; $display("FAIL wr_state_after_stop got=%0d exp=0", st); end
    temp = 16'h0000; hum = 16'h0000;
  endtask

  task automatic test_read_full();
    logic [7:0] exp_b [6];
    logic [7:0] d;
    logic a;
    exp_b = '{8'hBE, 8'hEF, CRC_T, 8'h12, 8'h34, CRC_H};
    unstable = 0;
    i2c_start();
    write_byte(8'h89, a);
    checks++; if (a !== 1'b1) begin failures++; $display("FAIL rd_addr_ack got=%b exp=1", a); end
    for (int k = 0; k < 6; k++) begin
      read_byte(k < 5, d);
      checks++; if (d !== exp_b[k]) begin failures++; $display("FAIL rd_byte%0d got=%h exp=%h", k, d, exp_b[k]); end
    end
    checks++; if (bs !== 3'd6) begin failures++; $display("FAIL rd_bytes_sent got=%0d exp=6", bs); end
    checks++; if (mv !== 1'b0) begin failures++; $display("FAIL rd_mv_cleared got=%b exp=0", mv); end
    checks++; if (st !== 3'd7) begin failures++; $display("FAIL rd_state_wait got=%0d exp=7", st); end
    checks++; if (unstable !== 0) begin failures++; $display("FAIL rd_sda_stable got=%0d exp=0", unstable); end
    i2c_stop();
    checks++; if (st !== 3'd0) begin failures++; $display("FAIL rd_state_after_stop got=%0d exp=0", st); end
  endtask

  task automatic test_read_no_meas();
    logic a;
    pulse_reset();
    i2c_start();
    write_byte(8'h89, a);
    checks++; if (a !== 1'b0) begin failures++; $display("FAIL nomeas_nack got=%b exp=0", a); end
    checks++; if (st !== 3'd7) begin failures++; $display("FAIL nomeas_state got=%0d exp=7", st); end
    i2c_stop();
    checks++; if (st !== 3'd0) begin failures++; $display("FAIL nomeas_state_stop got=%0d exp=0", st); end
  endtask

  task automatic test_wrong_addr();
    logic a;
    int n0;
    n0 = cv_count;
    i2c_start();
    write_byte(8'h8A, a);
    checks++; if (a !== 1'b0) begin failures++; $display("FAIL badaddr_nack got=%b exp=0", a); end
    checks++; if (st !== 3'd7) begin failures++; $display("FAIL badaddr_state got=%0d exp=7", st); end
    i2c_stop();
    checks++; if (st !== 3'd0) begin failures++; $display("FAIL badaddr_state_stop got=%0d exp=0", st); end
    checks++; if (cv_count !== n0) begin failures++; $display("FAIL badaddr_cv got=%0d exp=%0d", cv_count, n0); end
  endtask

  task automatic test_other_command();
    logic a0, a1, a2;
    int n0;
    n0 = cv_count;
    i2c_start();
    write_byte(8'h88, a0);
    write_byte(8'h12, a1);
    write_byte(8'h34, a2);
    i2c_stop();
    checks++; if ({a0, a1, a2} !== 3'b110) begin failures++; $display("FAIL other_acks got=%b exp=110", {a0, a1, a2}); end
    checks++; if (cmd !== 8'h12) begin failures++; $display("FAIL other_cmd got=%h exp=12", cmd); end
    checks++; if (cv_count - n0 !== 1) begin failures++; $display("FAIL other_cv got=%0d exp=1", cv_count - n0); end
    checks++; if (mv !== 1'b0) begin failures++; $display("FAIL other_no_snapshot got=%b exp=0", mv); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d0, d1, d2;
    logic a;
    do_meas(16'hBEEF, 16'h1234);
    temp = 16'h5555; hum = 16'hAAAA;
    i2c_start();
    write_byte(8'h89, a);
    read_byte(1'b1, d0);
    read_byte(1'b0, d1);
    checks++; if ({d0, d1} !== 16'hBEEF) begin failures++; $display("FAIL partial_bytes got=%h exp=BEEF", {d0, d1}); end
    checks++; if (sda_bus !== 1'b1 || st !== 3'd7) begin failures++; $display("FAIL partial_release got=%b/%0d exp=1/7", sda_bus, st); end
    checks++; if (bs !== 3'd2) begin failures++; $display("FAIL partial_bytes_sent got=%0d exp=2", bs); end
    checks++; if (mv !== 1'b1) begin failures++; $display("FAIL partial_mv_kept got=%b exp=1", mv); end
    i2c_start();
    write_byte(8'h89, a);
    checks++; if (a !== 1'b1) begin failures++; $display("FAIL rstart_ack got=%b exp=1", a); end
    read_byte(1'b0, d2);
    checks++; if (d2 !== 8'hBE) begin failures++; $display("FAIL rstart_first_byte got=%h exp=BE", d2); end
    i2c_stop();
    checks++; if (mv !== 1'b1) begin failures++; $display("FAIL rstart_mv got=%b exp=1", mv); end
  endtask

  task automatic test_reset_mid_read();
    logic a, r;
    do_meas(16'h0000, 16'h0000);
    i2c_start();
    write_byte(8'h89, a);
    for (int i = 0; i < 3; i++) clk_bit(1'b1, r);
    m_sda = 1'b1;
    #Q;
    checks++; if (sda_bus !== 1'b0) begin failures++; $display("FAIL midrst_driving got=%b exp=0", sda_bus); end
    Reset = 1'b1;
    #1;
    checks++; if (sda_bus !== 1'b1) begin failures++; $display("FAIL midrst_sda_release got=%b exp=1", sda_bus); end
    checks++; if ({st, cmd, cv, mv, bs} !== 16'h0000) begin failures++; $display("FAIL midrst_outputs got=%h exp=0000", {st, cmd, cv, mv, bs}); end
    #Q m_scl = 1'b1;
    @(negedge clk) Reset = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (st !== 3'd0 || mv !== 1'b0) begin failures++; $display("FAIL midrst_after got=%0d/%b exp=0/0", st, mv); end
  endtask

  initial begin
    test_reset();
    test_write_meas();
    test_read_full();
    test_read_no_meas();
    test_wrong_addr();
    test_other_command();
    test_back_to_back();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
